// File: rtl/soc_gpio_in_conditioner.sv
// GPIO pad input conditioning: two-flop synchronizer, per-bit stability debounce,
// registered edge pulses and sticky, maskable edge events feeding one interrupt.
module soc_gpio_in_conditioner #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_in,
    input  logic             bypass,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];

    // Debounce decision: a level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (bypass) begin
                stable_next[i] = s2[i];
            end else if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
        rise_next = ~stable & stable_next;
        fall_next = stable & ~stable_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            rise   <= '0;
            fall   <= '0;
            evt    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= pad_in;
            s2     <= s1;
            stable <= stable_next;
            rise   <= rise_next;
            fall   <= fall_next;
            // A new set outranks a simultaneous clear on the same bit.
            evt    <= (evt & ~evt_clr) | (rise_next & rise_en) | (fall_next & fall_en);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign gpio_in = stable;
    assign irq     = |evt;

endmodule
